xor_hash_core: RTL and testbench



---
 rtl/xor_hash_core.sv | 101 ++++++++++
 tb/tb_xor_hash_core.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/xor_hash_core.sv
// XOR-fold hash: folds a DATA_W-bit word into a HASH_W-bit digest using a balanced XOR tree.
// Define XOR_HASH_PIPE_EN to register the 8-lane partial fold (latency 2 instead of 1).
module xor_hash_core #(
  parameter int DATA_W = 512,
  parameter int HASH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  output logic [HASH_W-1:0] out,
  output logic              out_valid
);

  localparam int GROUP   = 8;
  localparam int N_LANES = DATA_W / HASH_W;
  localparam int N_WORDS = (N_LANES + GROUP - 1) / GROUP;
  localparam int FOLD_W  = GROUP * HASH_W;
  localparam int PAD_W   = N_WORDS * FOLD_W;

  // Zero-pad to whole fold words; zero lanes leave the XOR unchanged.
  logic [PAD_W-1:0]  in_pad;
  logic [FOLD_W-1:0] fold_c;
  logic [FOLD_W-1:0] fold_src;
  logic [HASH_W-1:0] digest_c;
  logic              stage_valid;
  logic [HASH_W-1:0] out_q, out_d;
  logic              out_valid_q;

  assign in_pad = PAD_W'(in);

  genvar gi, gj;

  // First level: fold the FOLD_W-bit words together, one reduction-XOR per column.
  generate
    for (gi = 0; gi < FOLD_W; gi++) begin : g_fold_bit
      logic [N_WORDS-1:0] col;
      for (gj = 0; gj < N_WORDS; gj++) begin : g_fold_word
        assign col[gj] = in_pad[gj*FOLD_W + gi];
      end
      assign fold_c[gi] = ^col;
    end
  endgenerate

`ifdef XOR_HASH_PIPE_EN
  logic [FOLD_W-1:0] fold_q, fold_d;
  logic              stage1_valid_q;

  always_comb begin
    fold_d = fold_q;
    if (in_valid) fold_d = fold_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fold_q         <= '0;
      stage1_valid_q <= 1'b0;
    end else begin
      fold_q         <= fold_d;
      stage1_valid_q <= in_valid;
    end
  end

  assign fold_src    = fold_q;
  assign stage_valid = stage1_valid_q;
`else
  assign fold_src    = fold_c;
  assign stage_valid = in_valid;
`endif

  // Second level: fold the GROUP lanes of the partial word into the digest.
  generate
    for (gi = 0; gi < HASH_W; gi++) begin : g_lane_bit
      logic [GROUP-1:0] col;
      for (gj = 0; gj < GROUP; gj++) begin : g_lane
        assign col[gj] = fold_src[gj*HASH_W + gi];
      end
      assign digest_c[gi] = ^col;
    end
  endgenerate

  // Output holds the last valid digest across bubbles.
  always_comb begin
    out_d = out_q;
    if (stage_valid) out_d = digest_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= stage_valid;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_xor_hash_core.sv
// Self-checking bench for xor_hash_core; expected digests queued at drive time, popped at output.
// Compile with the same XOR_HASH_PIPE_EN setting as the RTL.
module tb_xor_hash_core;

`ifdef XOR_HASH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_data;
  logic [7:0]   out_data;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [1:0] vpipe;
  logic [7:0] held;

  xor_hash_core #(.DATA_W(512), .HASH_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in_data),
    .out      (out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_hash(input logic [511:0] d);
    logic [7:0] h = 8'h00;
    for (int k = 0; k < 64; k++) h ^= d[k*8 +: 8];
    return h;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, then check out_valid and out against the model.
  task automatic step(input string tag, input logic v, input logic [511:0] d);
    logic       exp_v;
    logic [7:0] exp;
    in_valid = v;
    in_data  = d;
    if (v) sb.push_back(ref_hash(d));
    vpipe = {vpipe[0], v};
    exp_v = vpipe[LAT-1];
    @(posedge clk); #1;
    check({tag, "_valid"}, {7'b0, out_valid}, {7'b0, exp_v});
    if (exp_v) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 8'd0, 8'd1);
      end else begin
        exp  = sb.pop_front();
        check({tag, "_out"}, out_data, exp);
        held = exp;
      end
    end else begin
      check({tag, "_hold"}, out_data, held);
    end
    $display("step %-8s v=%0d in[15:0]=%h out=%h out_valid=%0b", tag, v, d[15:0], out_data, out_valid);
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    logic [511:0] w;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {512{1'b1}};
    vpipe    = 2'b00;
    held     = 8'h00;

    // Reset held with valid all-ones input
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_out", out_data, 8'h00);
      check("rst_valid", {7'b0, out_valid}, 8'h00);
    end
    rst = 1'b0;

    step("single", 1'b1, 512'h1);
    for (int i = 1; i < LAT; i++) step("drain", 1'b0, 512'h0);
    step("idle", 1'b0, 512'h0);

    w = '0; w[8] = 1'b1; w[0] = 1'b1;
    step("cancel", 1'b1, w);
    step("allones", 1'b1, {512{1'b1}});
    w = '0; w[511:504] = 8'hAB;
    step("toplane", 1'b1, w);
    for (int i = 1; i < LAT; i++) step("drain", 1'b0, 512'h0);
    step("idle", 1'b0, 512'h0);

    // Streaming back-to-back random words
    for (int i = 0; i < 10; i++) step("stream", 1'b1, rand_word());
    for (int i = 1; i < LAT; i++) step("drain", 1'b0, 512'h0);

    // Bubbles: digest must hold while idle data changes
    step("bub_v", 1'b1, 512'h1);
    for (int i = 1; i < LAT; i++) step("drain", 1'b0, rand_word());
    for (int i = 0; i < 3; i++) step("bubble", 1'b0, rand_word());
    check("bub_held", out_data, 8'h01);

    // Reset mid-stream with words in flight
    w = '0; w[7:0] = 8'h5A;
    step("pre_rst", 1'b1, w);
    in_valid = 1'b1;
    in_data  = rand_word();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_out", out_data, 8'h00);
    check("arst_valid", {7'b0, out_valid}, 8'h00);
    sb.delete();
    vpipe = 2'b00;
    held  = 8'h00;
    @(posedge clk); #1;
    check("rst_mid_out", out_data, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b0, rand_word());
    w = '0; w[263:256] = 8'h3C; w[7:0] = 8'h81;
    step("resume", 1'b1, w);
    for (int i = 1; i < LAT; i++) step("drain", 1'b0, 512'h0);
    step("idle", 1'b0, 512'h0);

    check("sb_left", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
